scanner_xfer_ctrl: RTL and testbench

- Parametrised next-generation scanner controller: simulates a filling scan buffer, announces fill thresholds to the output driver, and serialises command and data frames.
- Sits between the local transfer-control inputs (start request, peer half-full notice, downstream ready) and the serial output link to the output driver.
- Adds over the prior generation:
  - configurable depth, divider and data width;
  - one-shot threshold commands instead of repeating;
  - a pending-command mask;
  - whole-frame completion on every exit path.

---
 rtl/scanner_pkg.sv | 28 ++
 rtl/scanner_serializer.sv | 57 +++++
 rtl/scanner_xfer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_scanner_xfer_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared types and constants for the scanner transfer controller:
// state encoding, command codes, pending-mask bit positions, threshold helper.
package scanner_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVE   = 3'd1,
    STANDBY  = 3'd2,
    TRANSFER = 3'd3,
    FLUSH    = 3'd4
  } state_e;

  localparam int CMD_RDY   = 2;
  localparam int CMD_START = 3;
  localparam int CMD_FULL  = 4;
  localparam int CMD_DATA  = 7;

  localparam int PEND_RDY   = 0;
  localparam int PEND_START = 1;
  localparam int PEND_FULL  = 2;
  localparam int PEND_W     = 3;

  // Fill level that corresponds to tenths/10 of the buffer, truncated.
  function automatic int threshold(input int depth, input int tenths);
    return (depth * tenths) / 10;
  endfunction

endpackage

// File: rtl/scanner_serializer.sv
// LSB-first frame shifter: a CMD_W command optionally followed by DATA_W payload bits.
// Accepts a new frame during the last bit of the current one so frames can run back-to-back.
module scanner_serializer #(
  parameter int CMD_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic              with_data_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              ser_clk_o,
  output logic              ser_data_o
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign busy_o     = (cnt_q != '0);
  assign ready_o    = (cnt_q <= CNT_W'(1));
  assign ser_clk_o  = busy_o;
  assign ser_data_o = busy_o & shreg_q[0];

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i && ready_o) begin
      if (with_data_i) begin
        shreg_d = {data_i, cmd_i};
        cnt_d   = CNT_W'(FRAME_W);
      end else begin
        shreg_d = {{DATA_W{1'b0}}, cmd_i};
        cnt_d   = CNT_W'(CMD_W);
      end
    end else if (cnt_q != '0) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/scanner_xfer_ctrl.sv
// Scanner transfer controller: models a filling scan buffer, raises one-shot threshold
// commands and streams data frames to the output driver over a bit-serial link.
module scanner_xfer_ctrl
  import scanner_pkg::*;
#(
  parameter int DEPTH      = 10,
  parameter int SAMPLE_DIV = 8,
  parameter int DATA_W     = 8,
  parameter int CMD_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         peer_half,
  input  logic                         ready_for_transfer_in,
  output logic [2:0]                   ps,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         ser_clk,
  output logic                         ser_data,
  output logic                         ser_busy,
  output logic                         xfer_done
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);

  localparam logic [FILL_W-1:0] TH80      = FILL_W'(threshold(DEPTH, 8));
  localparam logic [FILL_W-1:0] TH90      = FILL_W'(threshold(DEPTH, 9));
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  state_e              state_q;
  logic [FILL_W-1:0]   fill_q;
  logic [DIV_W-1:0]    div_q;
  logic [PEND_W-1:0]   pending_q;
  logic                stop_q;
  logic                xfer_done_q;

  logic                tick;
  logic [FILL_W-1:0]   fill_inc;
  logic                scan_step;
  logic [PEND_W-1:0]   pend_set;
  logic [PEND_W-1:0]   pend_clr;
  logic                drain_needed;

  logic                ld;
  logic [CMD_W-1:0]    ld_cmd;
  logic                ld_with_data;
  logic                ser_ready;
  logic                ser_busy_w;

  // SAMPLE_DIV is a power of two, so the divider wraps naturally at all-ones.
  assign tick         = &div_q;
  assign fill_inc     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign scan_step    = (state_q == ACTIVE) && start && (fill_q != FILL_FULL) && tick;
  assign drain_needed = (pending_q != '0) || ser_busy_w;

  // Threshold commands fire only on the tick that crosses into the level.
  always_comb begin
    pend_set = '0;
    if (scan_step) begin
      pend_set[PEND_RDY]   = (fill_inc == TH80);
      pend_set[PEND_START] = (fill_inc == TH90);
      pend_set[PEND_FULL]  = (fill_inc == FILL_FULL);
    end
  end

  // Pending commands always win over the next data frame.
  always_comb begin
    ld           = 1'b0;
    ld_cmd       = '0;
    ld_with_data = 1'b0;
    pend_clr     = '0;
    if (ser_ready) begin
      if (pending_q[PEND_RDY]) begin
        ld                 = 1'b1;
        ld_cmd             = CMD_W'(CMD_RDY);
        pend_clr[PEND_RDY] = 1'b1;
      end else if (pending_q[PEND_START]) begin
        ld                   = 1'b1;
        ld_cmd               = CMD_W'(CMD_START);
        pend_clr[PEND_START] = 1'b1;
      end else if (pending_q[PEND_FULL]) begin
        ld                  = 1'b1;
        ld_cmd              = CMD_W'(CMD_FULL);
        pend_clr[PEND_FULL] = 1'b1;
      end else if (state_q == TRANSFER && start && !peer_half && !stop_q) begin
        ld           = 1'b1;
        ld_cmd       = CMD_W'(CMD_DATA);
        ld_with_data = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      div_q       <= '0;
      pending_q   <= '0;
      stop_q      <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      div_q       <= div_q + DIV_W'(1);
      pending_q   <= (pending_q & ~pend_clr) | pend_set;
      xfer_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          fill_q <= '0;
          stop_q <= 1'b0;
          if (tick && start) state_q <= ACTIVE;
        end
        ACTIVE, STANDBY: begin
          if (!start) begin
            if (drain_needed) begin
              state_q <= FLUSH;
            end else begin
              state_q <= IDLE;
              fill_q  <= '0;
            end
          end else if (state_q == ACTIVE) begin
            if (fill_q == FILL_FULL)
              state_q <= ready_for_transfer_in ? TRANSFER : STANDBY;
            else if (tick)
              fill_q <= fill_inc;
          end else if (peer_half || ready_for_transfer_in) begin
            state_q <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (!start) begin
            if (drain_needed) begin
              state_q <= FLUSH;
            end else begin
              state_q <= IDLE;
              fill_q  <= '0;
            end
          end else begin
            if (peer_half) stop_q <= 1'b1;
            // Exit only once the frame on the wire has fully left.
            if ((stop_q || peer_half) && !drain_needed) begin
              state_q     <= IDLE;
              fill_q      <= '0;
              stop_q      <= 1'b0;
              xfer_done_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!drain_needed) begin
            state_q <= IDLE;
            fill_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  scanner_serializer #(
    .CMD_W  (CMD_W),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk         (clk),
    .rst_ni      (rst),
    .load_i      (ld),
    .cmd_i       (ld_cmd),
    .with_data_i (ld_with_data),
    .data_i      (DATA_W'(fill_q)),
    .ready_o     (ser_ready),
    .busy_o      (ser_busy_w),
    .ser_clk_o   (ser_clk),
    .ser_data_o  (ser_data)
  );

  assign ps        = state_q;
  assign fill      = fill_q;
  assign ser_busy  = ser_busy_w;
  assign xfer_done = xfer_done_q;

endmodule

// File: tb/tb_scanner_xfer_ctrl.sv
// Directed bench for scanner_xfer_ctrl: cycle-indexed vector table plus a reset-mid-frame sequence.
module tb_scanner_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, peer0 = 1'b0, ready0 = 1'b0;
  logic start1 = 1'b0, peer1 = 1'b0, ready1 = 1'b0;
  logic [2:0] ps0, ps1;
  logic [3:0] fill0, fill1;
  logic sclk0, sdat0, busy0, done0;
  logic sclk1, sdat1, busy1, done1;

  always #5 clk = ~clk;

  scanner_xfer_ctrl #(.DEPTH(10), .SAMPLE_DIV(8), .DATA_W(8), .CMD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start0), .peer_half(peer0), .ready_for_transfer_in(ready0),
    .ps(ps0), .fill(fill0), .ser_clk(sclk0), .ser_data(sdat0), .ser_busy(busy0), .xfer_done(done0)
  );

  scanner_xfer_ctrl #(.DEPTH(10), .SAMPLE_DIV(2), .DATA_W(8), .CMD_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start1), .peer_half(peer1), .ready_for_transfer_in(ready1),
    .ps(ps1), .fill(fill1), .ser_clk(sclk1), .ser_data(sdat1), .ser_busy(busy1), .xfer_done(done1)
  );

  typedef struct {
    bit rst_first;
    bit sel;
    int at;
    int e_ps, e_fill, e_sclk, e_sdat, e_done;
    bit start, peer, ready;
  } vec_t;

  localparam int X = -1;

  vec_t tbl[$];
  int cyc = 0, base = 0;
  int checks = 0, errors = 0;
  bit q0[$], q1[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (sclk0) q0.push_back(sdat0);
      if (sclk1) q1.push_back(sdat1);
    end
  end

  function automatic vec_t mk(bit r, bit s, int at, int p, int f, int c, int d, int x,
                              bit st, bit pe, bit rd);
    vec_t v;
    v.rst_first = r; v.sel = s; v.at = at;
    v.e_ps = p; v.e_fill = f; v.e_sclk = c; v.e_sdat = d; v.e_done = x;
    v.start = st; v.peer = pe; v.ready = rd;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start0 = 0; peer0 = 0; ready0 = 0;
    start1 = 0; peer1 = 0; ready1 = 0;
    repeat (3) @(negedge clk);
    q0.delete();
    q1.delete();
    rst = 1'b1;
    base = cyc;
  endtask

  task automatic wait_until(input int at);
    int guard;
    guard = 0;
    while ((cyc - base) < at && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if ((cyc - base) != at) begin
      checks++;
      errors++;
      $display("FAIL wait_edge: got %0d expected %0d", cyc - base, at);
    end
  endtask

  task automatic run_vectors(input int lo, input int hi);
    vec_t v;
    int a_ps, a_fill, a_sclk, a_sdat, a_done;
    for (int i = lo; i < hi; i++) begin
      v = tbl[i];
      if (v.rst_first) do_reset();
      wait_until(v.at);
      if (v.sel) begin
        a_ps = ps1; a_fill = fill1; a_sclk = sclk1; a_sdat = sdat1; a_done = done1;
      end else begin
        a_ps = ps0; a_fill = fill0; a_sclk = sclk0; a_sdat = sdat0; a_done = done0;
      end
      $display("vec %0d dut%0d edge %0d: ps=%0d fill=%0d ser_clk=%0d ser_data=%0d xfer_done=%0d",
               i, v.sel, v.at, a_ps, a_fill, a_sclk, a_sdat, a_done);
      chk($sformatf("v%0d_ps", i), a_ps, v.e_ps);
      chk($sformatf("v%0d_fill", i), a_fill, v.e_fill);
      chk($sformatf("v%0d_ser_clk", i), a_sclk, v.e_sclk);
      chk($sformatf("v%0d_ser_data", i), a_sdat, v.e_sdat);
      chk($sformatf("v%0d_xfer_done", i), a_done, v.e_done);
      if (v.sel) begin
        start1 = v.start; peer1 = v.peer; ready1 = v.ready;
        start0 = 0; peer0 = 0; ready0 = 0;
      end else begin
        start0 = v.start; peer0 = v.peer; ready0 = v.ready;
        start1 = 0; peer1 = 0; ready1 = 0;
      end
    end
  endtask

  task automatic chk_stream(input bit sel, input logic [63:0] expv, input int n, input string name);
    logic [63:0] got;
    int len;
    got = '0;
    len = sel ? q1.size() : q0.size();
    for (int i = 0; i < len && i < 64; i++) got[i] = sel ? q1[i] : q0[i];
    $display("stream %s: %0d bits %h", name, len, got);
    chk({name, "_len"}, len, n);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s_bits: got %h expected %h", name, got, expv);
    end
  endtask

  initial begin
    int n_a, n_b, n_c, n_e, nclk;

    // A: scan to full with downstream ready, stream data, stop on peer_half
    tbl.push_back(mk(1,0,  0, 0, 0,0,0,0, 1,0,1));
    tbl.push_back(mk(0,0,  7, 0, 0,0,X,0, 1,0,1));
    tbl.push_back(mk(0,0,  8, 1, 0,0,X,0, 1,0,1));
    tbl.push_back(mk(0,0, 16, 1, 1,0,X,X, 1,0,1));
    tbl.push_back(mk(0,0, 72, 1, 8,0,X,X, 1,0,1));
    tbl.push_back(mk(0,0, 73, 1, 8,1,0,X, 1,0,1));
    tbl.push_back(mk(0,0, 74, X, X,1,1,X, 1,0,1));
    tbl.push_back(mk(0,0, 80, 1, 9,1,0,X, 1,0,1));
    tbl.push_back(mk(0,0, 81, X, 9,1,1,X, 1,0,1));
    tbl.push_back(mk(0,0, 82, X, X,1,1,X, 1,0,1));
    tbl.push_back(mk(0,0, 83, X, X,1,0,X, 1,0,1));
    tbl.push_back(mk(0,0, 88, 1,10,1,0,X, 1,0,1));
    tbl.push_back(mk(0,0, 89, 3,10,1,0,0, 1,0,1));
    tbl.push_back(mk(0,0, 91, 3, X,1,1,X, 1,0,1));
    tbl.push_back(mk(0,0, 97, 3,10,1,1,0, 1,0,1));
    tbl.push_back(mk(0,0,105, X, X,1,0,X, 1,0,1));
    tbl.push_back(mk(0,0,106, X, X,1,1,X, 1,0,1));
    tbl.push_back(mk(0,0,108, X, X,1,1,X, 1,0,1));
    tbl.push_back(mk(0,0,113, 3, X,1,1,0, 1,0,1));
    tbl.push_back(mk(0,0,115, 3, X,1,X,0, 1,1,1));
    tbl.push_back(mk(0,0,120, 3,10,1,X,0, 1,0,1));
    tbl.push_back(mk(0,0,128, 3,10,1,0,0, 1,0,1));
    tbl.push_back(mk(0,0,129, 3,10,0,0,0, 1,0,1));
    tbl.push_back(mk(0,0,130, 0, 0,0,0,1, 0,0,0));
    tbl.push_back(mk(0,0,131, 0, 0,0,0,0, 0,0,0));
    n_a = tbl.size();
    // B: downstream not ready -> STANDBY, peer_half pulse -> TRANSFER, then start drop -> FLUSH
    tbl.push_back(mk(1,0,  0, 0, 0,0,0,0, 1,0,0));
    tbl.push_back(mk(0,0, 88, 1,10,1,0,X, 1,0,0));
    tbl.push_back(mk(0,0, 89, 2,10,1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,100, 2,10,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,101, 3,10,0,0,0, 1,0,0));
    tbl.push_back(mk(0,0,102, 3,10,1,1,0, 1,0,0));
    tbl.push_back(mk(0,0,105, 3,10,1,X,0, 0,0,0));
    tbl.push_back(mk(0,0,106, 4,10,1,X,0, 0,0,0));
    tbl.push_back(mk(0,0,117, 4,10,1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,118, 4,10,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,119, 0, 0,0,0,0, 0,0,0));
    n_b = tbl.size();
    // C: start dropped in ACTIVE while 0x03 is shifting
    tbl.push_back(mk(1,0,  0, 0, 0,0,0,0, 1,0,1));
    tbl.push_back(mk(0,0, 84, 1, 9,1,0,0, 0,0,1));
    tbl.push_back(mk(0,0, 85, 4, 9,1,0,0, 0,0,1));
    tbl.push_back(mk(0,0, 88, 4, 9,1,0,0, 0,0,1));
    tbl.push_back(mk(0,0, 89, 4, 9,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0, 90, 0, 0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0,100, 0, 0,0,0,0, 0,0,0));
    n_c = tbl.size();
    // E: SAMPLE_DIV=2, thresholds arrive while earlier commands are still shifting
    tbl.push_back(mk(1,1,  0, 0, 0,0,0,0, 1,0,0));
    tbl.push_back(mk(0,1,  2, 1, 0,0,X,0, 1,0,0));
    tbl.push_back(mk(0,1,  4, 1, 1,0,X,X, 1,0,0));
    tbl.push_back(mk(0,1, 18, 1, 8,0,X,X, 1,0,0));
    tbl.push_back(mk(0,1, 19, 1, 8,1,0,X, 1,0,0));
    tbl.push_back(mk(0,1, 20, 1, 9,1,1,X, 1,0,0));
    tbl.push_back(mk(0,1, 22, 1,10,1,X,X, 1,0,0));
    tbl.push_back(mk(0,1, 23, 2,10,1,X,0, 1,0,0));
    tbl.push_back(mk(0,1, 26, 2,10,1,0,X, 1,0,0));
    tbl.push_back(mk(0,1, 27, 2,10,1,1,X, 1,0,0));
    tbl.push_back(mk(0,1, 28, X, X,1,1,X, 1,0,0));
    tbl.push_back(mk(0,1, 29, X, X,1,0,X, 1,0,0));
    tbl.push_back(mk(0,1, 35, 2,10,1,0,X, 1,0,0));
    tbl.push_back(mk(0,1, 37, X, X,1,1,X, 1,0,0));
    tbl.push_back(mk(0,1, 42, 2,10,1,0,0, 1,0,0));
    tbl.push_back(mk(0,1, 43, 2,10,0,0,0, 1,0,0));
    n_e = tbl.size();

    run_vectors(0, n_a);
    chk_stream(1'b0, 64'h000A070A07040302, 56, "stream_A");
    run_vectors(n_a, n_b);
    chk_stream(1'b0, 64'h0000000A07040302, 40, "stream_B");
    run_vectors(n_b, n_c);
    chk_stream(1'b0, 64'h0000000000000302, 16, "stream_C");
    run_vectors(n_c, n_e);
    chk_stream(1'b1, 64'h0000000000040302, 24, "stream_E");

    // D: reset asserted in the middle of a data frame
    do_reset();
    start0 = 1; ready0 = 1;
    wait_until(100);
    $display("seq D edge 100: ps=%0d fill=%0d ser_clk=%0d", ps0, fill0, sclk0);
    chk("D_pre_ps", ps0, 3);
    chk("D_pre_fill", fill0, 10);
    chk("D_pre_ser_clk", sclk0, 1);
    #2 rst = 1'b0;
    #1;
    $display("seq D async reset: ps=%0d fill=%0d ser_clk=%0d ser_data=%0d ser_busy=%0d xfer_done=%0d",
             ps0, fill0, sclk0, sdat0, busy0, done0);
    chk("D_rst_ps", ps0, 0);
    chk("D_rst_fill", fill0, 0);
    chk("D_rst_ser_clk", sclk0, 0);
    chk("D_rst_ser_data", sdat0, 0);
    chk("D_rst_ser_busy", busy0, 0);
    chk("D_rst_xfer_done", done0, 0);
    nclk = 0;
    repeat (10) begin
      @(negedge clk);
      if (sclk0) nclk++;
    end
    start0 = 0;
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sclk0) nclk++;
    end
    $display("seq D after reset: ser_clk pulses=%0d ps=%0d", nclk, ps0);
    chk("D_no_resume", nclk, 0);
    chk("D_post_ps", ps0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
